data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_if.sv | 32 +++
 rtl/data_sram_responder.sv | 117 +++++++++++
 tb/tb_data_sram_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if
//   Data SRAM request/response bundle between the CPU core (master) and the
//   data_sram_responder (slave).
//   Signals:
//     data_sram_en    : access request this cycle
//     data_sram_wen   : byte-lane write enables, 4'b0000 = read
//     data_sram_addr  : byte address, bits [1:0] ignored
//     data_sram_wdata : write data, lane i = bits [8i+7:8i]
//     data_sram_rdata : registered read data, one-cycle latency
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en,
      output data_sram_wen,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en,
      input  data_sram_wen,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Responder end of the CPU data SRAM port. Holds a single-port word RAM
//   with byte-lane writes and a small register window (LED, number display,
//   optional free-running timer). Read data returns with one-cycle latency.
//   Optional feature macro: DSRAM_TIMER_EN builds the TIMER register at
//   window offset 16'hE000; without it that offset is unmapped.
//   Parameters:
//     ADDR_WIDTH : word-address bits of the RAM (depth 2**ADDR_WIDTH words)
//     MMIO_HI    : addr[31:16] value selecting the register window
//   Ports:
//     clk      : clock, all state on rising edge
//     resetn   : asynchronous active-low reset (RAM contents not reset)
//     bus      : data SRAM request/response bundle (slave side)
//     led      : LED register (16 bits)
//     num_data : number-display register (32 bits)
module data_sram_responder #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [15:0] MMIO_HI    = 16'hBFAF
) (
   input  logic                  clk,
   input  logic                  resetn,
   data_sram_responder_if.slave  bus,
   output logic [15:0]           led,
   output logic [31:0]           num_data
);

   localparam logic [15:0] OFF_LED   = 16'hF000;
   localparam logic [15:0] OFF_NUM   = 16'hF010;
   localparam logic [15:0] OFF_TIMER = 16'hE000;

   logic [31:0] mem [2**ADDR_WIDTH];

   logic                  acc_wr;
   logic                  acc_rd;
   logic                  is_mmio;
   logic [15:0]           off;
   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           mmio_rdata;
   logic                  unused_ok;

   assign acc_wr    = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
   assign acc_rd    = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
   assign is_mmio   = (bus.data_sram_addr[31:16] == MMIO_HI);
   assign off       = bus.data_sram_addr[15:0];
   assign idx       = bus.data_sram_addr[ADDR_WIDTH+1:2];
   assign unused_ok = ^bus.data_sram_addr[1:0];

   function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
      logic [31:0] r;
      r = old_w;
      for (int unsigned i = 0; i < 4; i++) begin
         if (lanes[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

`ifdef DSRAM_TIMER_EN
   logic [31:0] timer;

   // A write loads the merged value instead of incrementing this edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         timer <= '0;
      end else if (acc_wr && is_mmio && (off == OFF_TIMER)) begin
         timer <= lane_merge(timer, bus.data_sram_wdata, bus.data_sram_wen);
      end else begin
         timer <= timer + 32'd1;
      end
   end
`endif

   always_comb begin
      mmio_rdata = '0;
      case (off)
         OFF_LED:   mmio_rdata = {16'h0000, led};
         OFF_NUM:   mmio_rdata = num_data;
`ifdef DSRAM_TIMER_EN
         OFF_TIMER: mmio_rdata = timer;
`endif
         default:   mmio_rdata = '0;
      endcase
   end

   // The reset branch is empty on purpose: RAM contents survive reset, but
   // a write sampled while resetn is low must still be discarded.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
      end else if (acc_wr && !is_mmio) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.data_sram_wen[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.data_sram_rdata <= '0;
         led                 <= '0;
         num_data            <= '0;
      end else begin
         if (acc_rd) begin
            bus.data_sram_rdata <= is_mmio ? mmio_rdata : mem[idx];
         end
         if (acc_wr && is_mmio && (off == OFF_LED)) begin
            // Only lanes 0-1 exist; upper lane enables are ignored.
            if (bus.data_sram_wen[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
            if (bus.data_sram_wen[1]) led[15:8] <= bus.data_sram_wdata[15:8];
         end
         if (acc_wr && is_mmio && (off == OFF_NUM)) begin
            num_data <= lane_merge(num_data, bus.data_sram_wdata, bus.data_sram_wen);
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder
//   Directed self-checking bench for data_sram_responder. Expected values
//   are hand-computed constants. Timer expectations follow DSRAM_TIMER_EN.
module tb_data_sram_responder;

   logic        clk;
   logic        resetn;
   logic [15:0] led;
   logic [31:0] num_data;
   int          tests;
   int          fails;

   data_sram_responder_if bus ();

   data_sram_responder #(
      .ADDR_WIDTH (10),
      .MMIO_HI    (16'hBFAF)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .bus      (bus.slave),
      .led      (led),
      .num_data (num_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t required < 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic en, input logic [3:0] wen,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.data_sram_en    = en;
      bus.data_sram_wen   = wen;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i % 2 == 0) drive(1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
         else            drive(1'b1, 4'h0, 32'h0000_0000, 32'h0);
         tick();
         tests++;
         if (bus.data_sram_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata[%0d]: got %h expected %h", i, bus.data_sram_rdata, 32'h0);
         end
         tests++;
         if (led !== 16'h0) begin
            fails++;
            $display("FAIL reset_led[%0d]: got %h expected %h", i, led, 16'h0);
         end
         tests++;
         if (num_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_num[%0d]: got %h expected %h", i, num_data, 32'h0);
         end
      end
      resetn = 1'b1;
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tick();
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 4'hF, 32'h0000_0030, 32'h1111_1111);
      tick();
      drive(1'b1, 4'hF, 32'hBFAF_F000, 32'h0000_00FF);
      tick();
      drive(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      tick();
      tests++;
      if (led !== 16'h00FF) begin
         fails++;
         $display("FAIL mid_led_pre: got %h expected %h", led, 16'h00FF);
      end
      tests++;
      if (bus.data_sram_rdata !== 32'h0000_00FF) begin
         fails++;
         $display("FAIL mid_rdata_pre: got %h expected %h", bus.data_sram_rdata, 32'h0000_00FF);
      end
      // Assert reset between edges: clearing must not wait for a clock.
      drive(1'b1, 4'hF, 32'h0000_0030, 32'h7777_7777);
      #2;
      resetn = 1'b0;
      #1;
      tests++;
      if (led !== 16'h0) begin
         fails++;
         $display("FAIL mid_led_async: got %h expected %h", led, 16'h0);
      end
      tests++;
      if (bus.data_sram_rdata !== 32'h0) begin
         fails++;
         $display("FAIL mid_rdata_async: got %h expected %h", bus.data_sram_rdata, 32'h0);
      end
      // RAM write sampled during reset must be dropped.
      tick();
      resetn = 1'b1;
      drive(1'b1, 4'h0, 32'h0000_0030, 32'h0);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'h1111_1111) begin
         fails++;
         $display("FAIL mid_ram_write_dropped: got %h expected %h", bus.data_sram_rdata, 32'h1111_1111);
      end
      tests++;
      if (led !== 16'h0) begin
         fails++;
         $display("FAIL mid_led_post: got %h expected %h", led, 16'h0);
      end
   endtask

   task automatic test_byte_lanes();
      drive(1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
      tick();
      drive(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
      tick();
      drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'h11BB_33DD) begin
         fails++;
         $display("FAIL byte_lanes: got %h expected %h", bus.data_sram_rdata, 32'h11BB_33DD);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 4'hF, 32'h0000_0020, 32'hCAFE_F00D);
      tick();
      drive(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      tick();
      drive(1'b0, 4'hF, 32'h0000_0024, 32'h9999_9999);
      tests++;
      if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL b2b_read: got %h expected %h", bus.data_sram_rdata, 32'hCAFE_F00D);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
            fails++;
            $display("FAIL b2b_hold_idle[%0d]: got %h expected %h", i, bus.data_sram_rdata, 32'hCAFE_F00D);
         end
      end
      drive(1'b1, 4'hF, 32'h0000_0020, 32'h0BAD_0BAD);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'hCAFE_F00D) begin
         fails++;
         $display("FAIL b2b_hold_write: got %h expected %h", bus.data_sram_rdata, 32'hCAFE_F00D);
      end
      drive(1'b1, 4'h0, 32'h0000_0020, 32'h0);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'h0BAD_0BAD) begin
         fails++;
         $display("FAIL b2b_rewrite: got %h expected %h", bus.data_sram_rdata, 32'h0BAD_0BAD);
      end
   endtask

   task automatic test_aliasing();
      drive(1'b1, 4'hF, 32'h0000_1004, 32'h5A5A_5A5A);
      tick();
      drive(1'b1, 4'h0, 32'h0000_0004, 32'h0);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'h5A5A_5A5A) begin
         fails++;
         $display("FAIL alias: got %h expected %h", bus.data_sram_rdata, 32'h5A5A_5A5A);
      end
   endtask

   task automatic test_mmio();
      drive(1'b1, 4'hF, 32'hBFAF_F000, 32'hDEAD_BEEF);
      tick();
      tests++;
      if (led !== 16'hBEEF) begin
         fails++;
         $display("FAIL mmio_led: got %h expected %h", led, 16'hBEEF);
      end
      drive(1'b1, 4'hF, 32'hBFAF_F010, 32'hDEAD_BEEF);
      tick();
      tests++;
      if (num_data !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL mmio_num: got %h expected %h", num_data, 32'hDEAD_BEEF);
      end
      drive(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
      tick();
      tests++;
      if (bus.data_sram_rdata !== 32'h0000_BEEF) begin
         fails++;
         $display("FAIL mmio_read_led: got %h expected %h", bus.data_sram_rdata, 32'h0000_BEEF);
      end
      drive(1'b1, 4'h0, 32'hBFAF_F100, 32'h0);
      tick();
      tests++;
      if (bus.data_sram_rdata !== 32'h0) begin
         fails++;
         $display("FAIL mmio_read_unmapped: got %h expected %h", bus.data_sram_rdata, 32'h0);
      end
      // Lane 1 only updates led[15:8]; lanes 2-3 on LED are ignored.
      drive(1'b1, 4'b0010, 32'hBFAF_F000, 32'h0000_A500);
      tick();
      drive(1'b1, 4'b1100, 32'hBFAF_F000, 32'hFFFF_0000);
      tick();
      tests++;
      if (led !== 16'hA5EF) begin
         fails++;
         $display("FAIL mmio_led_lanes: got %h expected %h", led, 16'hA5EF);
      end
      drive(1'b1, 4'b0001, 32'hBFAF_F010, 32'h0000_0042);
      tick();
      drive(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      tests++;
      if (bus.data_sram_rdata !== 32'hDEAD_BE42) begin
         fails++;
         $display("FAIL mmio_read_num: got %h expected %h", bus.data_sram_rdata, 32'hDEAD_BE42);
      end
   endtask

   task automatic test_timer();
      logic [31:0] exp_seq [3];
`ifdef DSRAM_TIMER_EN
      exp_seq[0] = 32'hFFFF_FFFE;
      exp_seq[1] = 32'hFFFF_FFFF;
      exp_seq[2] = 32'h0000_0000;
`else
      exp_seq[0] = 32'h0;
      exp_seq[1] = 32'h0;
      exp_seq[2] = 32'h0;
`endif
      drive(1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
      tick();
      drive(1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (bus.data_sram_rdata !== exp_seq[i]) begin
            fails++;
            $display("FAIL timer_read[%0d]: got %h expected %h", i, bus.data_sram_rdata, exp_seq[i]);
         end
      end
      drive(1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      drive(1'b0, 4'h0, 32'h0, 32'h0);
      test_reset();
      test_reset_midstream();
      test_byte_lanes();
      test_back_to_back();
      test_aliasing();
      test_mmio();
      test_timer();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
